wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 WR_pc  input  32  PC of instruction in WB; carried through, no functional use.
REQ-004 WR_pc_plus4  input  32  return address for jal/jalr.
REQ-005 WR_dout  input  32  load data from data memory.
REQ-006 WR_ALUresult  input  32  ALU result.
REQ-007 WR_Rw  input  5  destination register index.
REQ-008 WR_RegWrite  input  1  write enable for the destination register.
REQ-009 WR_MemtoReg  input  1  select load data as the write value.
REQ-010 WR_jal, WR_jalr  input  1 each  select the return address as the write value.
REQ-011 Ra, Rb  input  5 each  read-port register indices.
REQ-012 busA, busB  output  32 each  read-port data.
REQ-013 wb_data  output  32  selected write-back value, exported for the forwarding unit.
REQ-014 wb_count  output  32  number of committed register writes.

Function
REQ-015 wb_data SHALL be combinational: WR_pc_plus4 if (WR_jal|WR_jalr); else WR_dout if WR_MemtoReg; else WR_ALUresult. The jal/jalr select has priority over MemtoReg.
REQ-016 Storage SHALL be 31 x 32-bit registers, r1..r31. r0 SHALL NOT be stored.
REQ-017 A commit SHALL occur when WR_RegWrite=1 and WR_Rw!=0. On each rising clk edge with a commit, r[WR_Rw] <= wb_data.
REQ-018 WR_RegWrite=1 with WR_Rw=0 SHALL change no register and SHALL NOT count as a commit.
REQ-019 Reads SHALL be combinational (zero latency). Ra=0 or Rb=0 SHALL return 32'h0 regardless of pending writes.
REQ-020 Ra=Rb SHALL return identical data on both ports.
REQ-021 wb_count SHALL increment by 1 on each rising edge with a commit.
REQ-022 wb_count SHALL wrap from 32'hFFFFFFFF to 0, with no sticky flag.
REQ-023 X/unknown control inputs during reset SHALL NOT corrupt state. Reset dominates clk.

Reset
REQ-024 Asserting rst SHALL immediately clear r1..r31 and wb_count to 0, independent of clk.
REQ-025 While rst=1, busA and busB SHALL read 0 (non-bypass), and no write SHALL occur.
REQ-026 Deasserting rst between edges SHALL cause the first write to occur at the next rising edge with a commit.
REQ-027 rst asserted mid-sequence SHALL discard the in-flight commit of that cycle.

Configuration
REQ-028 Macro WB_BYPASS_EN SHALL control write-to-read bypass.
- Defined: when a commit is pending this cycle and Ra (Rb) equals WR_Rw, busA (busB) SHALL return wb_data in the same cycle (write-before-read).
- Not defined: busA/busB SHALL return the stored value, and the new value is visible from the cycle after the edge. The external forwarding unit covers the hazard.
- In both modes, r0 SHALL read as 0 and storage behaviour SHALL be identical.

Verification
REQ-029 Reset then read all 32 indices -> every bus reads 0, wb_count=0.
REQ-030 Write precedence:
- WR_RegWrite=1, WR_Rw=5, WR_MemtoReg=1, WR_dout=32'hDEADBEEF, WR_ALUresult=32'h1234 -> after edge, Ra=5 gives busA=32'hDEADBEEF and wb_count=1.
- WR_jal=1, WR_MemtoReg=1, WR_pc_plus4=32'h00400008, WR_Rw=31 -> r31=32'h00400008.
REQ-031 r0 protection: WR_RegWrite=1, WR_Rw=0, WR_ALUresult=32'hFFFFFFFF -> Ra=0 gives 0, wb_count unchanged.
REQ-032 Bypass: same cycle, commit to r7 with 32'hA5A5A5A5 while Ra=Rb=7 and r7 old value 32'h1.
- With WB_BYPASS_EN: busA=busB=32'hA5A5A5A5 before the edge.
- Without: busA=busB=32'h1 before the edge and 32'hA5A5A5A5 after.
REQ-033 Wrap and async reset:
- Preload wb_count=32'hFFFFFFFF (via forced state), one commit -> wb_count=0.
- Then assert rst mid-cycle (not on an edge) -> registers and wb_count clear immediately, and that cycle's commit is dropped.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile -- write-back stage register file for a 32-register RISC pipeline.
//
// Holds r1..r31 (r0 is hardwired to zero and never stored), selects the
// write-back value from the WB stage controls, and counts committed writes.
// Reads are combinational; writes land on the rising edge of clk.
//
// Optional feature: define WB_BYPASS_EN to forward a same-cycle commit onto
// the read ports (write-before-read). With the macro undefined, the read
// ports show only stored state and a new value becomes visible from the
// cycle after the edge, leaving the hazard to the external forwarding unit.
module wb_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] WR_pc,
    input  logic [31:0] WR_pc_plus4,
    input  logic [31:0] WR_dout,
    input  logic [31:0] WR_ALUresult,
    input  logic [4:0]  WR_Rw,
    input  logic        WR_RegWrite,
    input  logic        WR_MemtoReg,
    input  logic        WR_jal,
    input  logic        WR_jalr,
    input  logic [4:0]  Ra,
    input  logic [4:0]  Rb,
    output logic [31:0] busA,
    output logic [31:0] busB,
    output logic [31:0] wb_data,
    output logic [31:0] wb_count
);

    // The PC travels with the instruction for debug visibility only; it is
    // folded into a deliberately unused net so it is still consumed.
    logic        unused_pc;
    assign unused_pc = ^WR_pc;

    // ------------------------------------------------------------------
    // Write-back value selection
    // ------------------------------------------------------------------
    logic [31:0] wb_data_d;

    // Link address beats load data, which beats the ALU result.
    always_comb begin
        wb_data_d = WR_ALUresult;
        if (WR_jal || WR_jalr) begin
            wb_data_d = WR_pc_plus4;
        end else if (WR_MemtoReg) begin
            wb_data_d = WR_dout;
        end
    end

    assign wb_data = wb_data_d;

    // ------------------------------------------------------------------
    // Commit qualification and destination decode
    // ------------------------------------------------------------------
    // A write to r0 is not a commit: it touches no storage and is not counted.
    logic        commit;
    logic [31:1] wr_sel;

    assign commit = WR_RegWrite && (WR_Rw != 5'd0);

    // ------------------------------------------------------------------
    // Register storage r1..r31
    // ------------------------------------------------------------------
    // Each register sits in its own generate slice with an async clear,
    // so reset empties the whole file immediately without waiting for clk.
    // rd_view gives the read muxes one indexable array with r0 tied to zero.
    logic [31:0] rd_view [32];

    assign rd_view[0] = 32'h0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_reg
            logic [31:0] r_q;
            logic [31:0] r_d;

            assign wr_sel[gi] = commit && (WR_Rw == 5'(gi));

            // Hold unless this register is the committed destination.
            always_comb begin
                r_d = r_q;
                if (wr_sel[gi]) begin
                    r_d = wb_data_d;
                end
            end

            // Reset branch wins over any (possibly unknown) write controls.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= 32'h0;
                end else begin
                    r_q <= r_d;
                end
            end

            assign rd_view[gi] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Commit counter
    // ------------------------------------------------------------------
    logic [31:0] wb_count_q;
    logic [31:0] wb_count_d;

    // Free-running count of commits; wraps silently at 2^32.
    always_comb begin
        wb_count_d = wb_count_q;
        if (commit) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    // Counter state, cleared asynchronously together with the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_q <= 32'h0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_count = wb_count_q;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [31:0] stored_a;
    logic [31:0] stored_b;

    assign stored_a = rd_view[Ra];
    assign stored_b = rd_view[Rb];

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding. commit already excludes r0, so an index of 0
    // can never hit; reset suppresses forwarding so the ports read zero.
    logic hit_a;
    logic hit_b;

    assign hit_a = commit && !rst && (Ra == WR_Rw);
    assign hit_b = commit && !rst && (Rb == WR_Rw);

    // Forward the pending write-back value when the read index matches.
    always_comb begin
        busA = stored_a;
        busB = stored_b;
        if (hit_a) begin
            busA = wb_data_d;
        end
        if (hit_b) begin
            busB = wb_data_d;
        end
    end
`else
    // Stored state only; a write becomes visible the cycle after its edge.
    always_comb begin
        busA = stored_a;
        busB = stored_b;
    end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- directed self-checking bench for wb_regfile.
// Expected values are queued when a step is driven and popped when the
// matching DUT output is sampled (negedge plus 1 time unit, away from posedge).
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [31:0] WR_pc;
    logic [31:0] WR_pc_plus4;
    logic [31:0] WR_dout;
    logic [31:0] WR_ALUresult;
    logic [4:0]  WR_Rw;
    logic        WR_RegWrite;
    logic        WR_MemtoReg;
    logic        WR_jal;
    logic        WR_jalr;
    logic [4:0]  Ra;
    logic [4:0]  Rb;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] wb_data;
    logic [31:0] wb_count;

    wb_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .WR_pc        (WR_pc),
        .WR_pc_plus4  (WR_pc_plus4),
        .WR_dout      (WR_dout),
        .WR_ALUresult (WR_ALUresult),
        .WR_Rw        (WR_Rw),
        .WR_RegWrite  (WR_RegWrite),
        .WR_MemtoReg  (WR_MemtoReg),
        .WR_jal       (WR_jal),
        .WR_jalr      (WR_jalr),
        .Ra           (Ra),
        .Rb           (Rb),
        .busA         (busA),
        .busB         (busB),
        .wb_data      (wb_data),
        .wb_count     (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model [32];
    logic [31:0] exp_cnt;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) begin
                n_pass++;
                $display("check %-14s observed=%h", e.tag, obs);
            end else begin
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic idle();
        WR_RegWrite = 1'b0;
        WR_MemtoReg = 1'b0;
        WR_jal      = 1'b0;
        WR_jalr     = 1'b0;
    endtask

    task automatic drive_alu(input logic [4:0] rw, input logic [31:0] val);
        WR_RegWrite  = 1'b1;
        WR_MemtoReg  = 1'b0;
        WR_jal       = 1'b0;
        WR_jalr      = 1'b0;
        WR_Rw        = rw;
        WR_ALUresult = val;
        WR_dout      = ~val;
        WR_pc_plus4  = val ^ 32'h5555_0000;
    endtask

    initial begin
        // Reset with unknown controls and a would-be commit in flight.
        rst          = 1'b1;
        WR_pc        = 32'h0040_0000;
        WR_pc_plus4  = 32'h0;
        WR_dout      = 32'h0;
        WR_ALUresult = 32'h0;
        WR_Rw        = 5'bx;
        WR_RegWrite  = 1'bx;
        WR_MemtoReg  = 1'bx;
        WR_jal       = 1'b0;
        WR_jalr      = 1'b0;
        Ra           = 5'd3;
        Rb           = 5'd3;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        @(negedge clk);
        drive_alu(5'd3, 32'h55);
        #1;
        push("rst_busA", 32'h0);  pop_check(busA);
        push("rst_busB", 32'h0);  pop_check(busB);
        push("rst_count", 32'h0); pop_check(wb_count);
        @(negedge clk);
        #1;
        push("rst_nowrite", 32'h0); pop_check(busA);
        push("rst_count2", 32'h0);  pop_check(wb_count);
        #2 rst = 1'b0;
        idle();

        // Every index reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            Ra = 5'(i);
            Rb = 5'(31 - i);
            #1;
            push($sformatf("clr_A_r%0d", i), 32'h0); pop_check(busA);
            push($sformatf("clr_B_r%0d", 31 - i), 32'h0); pop_check(busB);
        end
        push("clr_count", 32'h0); pop_check(wb_count);

        // Load data beats ALU result.
        @(negedge clk);
        WR_RegWrite = 1'b1; WR_Rw = 5'd5; WR_MemtoReg = 1'b1;
        WR_dout = 32'hDEAD_BEEF; WR_ALUresult = 32'h0000_1234;
        WR_pc_plus4 = 32'h0040_0004;
        #1;
        push("sel_mem", 32'hDEAD_BEEF); pop_check(wb_data);
        push("r5_load", 32'hDEAD_BEEF);
        push("count_1", 32'd1);
        @(negedge clk);
        idle(); Ra = 5'd5;
        #1;
        pop_check(busA);
        pop_check(wb_count);

        // jal beats MemtoReg.
        @(negedge clk);
        WR_RegWrite = 1'b1; WR_jal = 1'b1; WR_MemtoReg = 1'b1; WR_Rw = 5'd31;
        WR_pc_plus4 = 32'h0040_0008; WR_dout = 32'h1111_1111; WR_ALUresult = 32'h2222_2222;
        #1;
        push("sel_jal", 32'h0040_0008); pop_check(wb_data);
        push("r31_jal", 32'h0040_0008);
        push("count_2", 32'd2);
        @(negedge clk);
        idle(); Rb = 5'd31;
        #1;
        pop_check(busB);
        pop_check(wb_count);

        // jalr alone selects the link address.
        @(negedge clk);
        WR_RegWrite = 1'b1; WR_jalr = 1'b1; WR_Rw = 5'd30;
        WR_pc_plus4 = 32'h1234_5678; WR_dout = 32'h3333_3333; WR_ALUresult = 32'h4444_4444;
        #1;
        push("sel_jalr", 32'h1234_5678); pop_check(wb_data);
        push("r30_jalr", 32'h1234_5678);
        @(negedge clk);
        idle(); Ra = 5'd30;
        #1;
        pop_check(busA);

        // ALU path: r7 = 1, used as the old value for the bypass step.
        @(negedge clk);
        drive_alu(5'd7, 32'h1);
        #1;
        push("sel_alu", 32'h1); pop_check(wb_data);
        @(negedge clk);
        idle(); Ra = 5'd7;
        #1;
        push("r7_alu", 32'h1); pop_check(busA);
        push("count_4", 32'd4); pop_check(wb_count);

        // r0 write is ignored and not counted.
        @(negedge clk);
        drive_alu(5'd0, 32'hFFFF_FFFF); Ra = 5'd0; Rb = 5'd0;
        #1;
        push("r0_pending", 32'h0); pop_check(busA);
        @(negedge clk);
        idle();
        #1;
        push("r0_after", 32'h0);  pop_check(busB);
        push("r0_count", 32'd4);  pop_check(wb_count);

        // Same-cycle write/read of r7.
        @(negedge clk);
        drive_alu(5'd7, 32'hA5A5_A5A5); Ra = 5'd7; Rb = 5'd7;
        #1;
`ifdef WB_BYPASS_EN
        push("byp_A_pre", 32'hA5A5_A5A5); pop_check(busA);
        push("byp_B_pre", 32'hA5A5_A5A5); pop_check(busB);
`else
        push("byp_A_pre", 32'h1); pop_check(busA);
        push("byp_B_pre", 32'h1); pop_check(busB);
`endif
        @(negedge clk);
        idle();
        #1;
        push("byp_A_post", 32'hA5A5_A5A5); pop_check(busA);
        push("byp_B_post", 32'hA5A5_A5A5); pop_check(busB);
        push("count_5", 32'd5); pop_check(wb_count);
        exp_cnt = 32'd5;

        // Random data into r10..r14, then read back against the model.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            model[10 + k] = $urandom;
            drive_alu(5'(10 + k), model[10 + k]);
            exp_cnt = exp_cnt + 32'd1;
        end
        @(negedge clk);
        idle();
        for (int k = 0; k < 5; k++) begin
            Ra = 5'(10 + k);
            Rb = 5'(14 - k);
            #1;
            push($sformatf("rnd_A_r%0d", 10 + k), model[10 + k]); pop_check(busA);
            push($sformatf("rnd_B_r%0d", 14 - k), model[14 - k]); pop_check(busB);
        end
        push("rnd_count", exp_cnt); pop_check(wb_count);

        // Counter wrap from the all-ones state.
        @(negedge clk);
        dut.wb_count_q <= 32'hFFFF_FFFF;
        drive_alu(5'd9, 32'h99);
        #1;
        push("wrap_pre", 32'hFFFF_FFFF); pop_check(wb_count);
        @(negedge clk);
        idle(); Ra = 5'd9;
        #1;
        push("wrap_zero", 32'h0); pop_check(wb_count);
        push("r9_wrap", 32'h99);  pop_check(busA);

        // Reset asserted mid-cycle with a commit in flight.
        @(negedge clk);
        drive_alu(5'd9, 32'h77); Ra = 5'd5; Rb = 5'd9;
        #1;
`ifdef WB_BYPASS_EN
        push("pre_rst_B", 32'h77); pop_check(busB);
`else
        push("pre_rst_B", 32'h99); pop_check(busB);
`endif
        #1 rst = 1'b1;
        #1;
        push("arst_A", 32'h0);     pop_check(busA);
        push("arst_B", 32'h0);     pop_check(busB);
        push("arst_count", 32'h0); pop_check(wb_count);
        @(negedge clk);
        #1;
        push("arst_drop", 32'h0);  pop_check(busB);
        push("arst_cnt2", 32'h0);  pop_check(wb_count);

        // Release between edges; the next edge performs the first write.
        #2 rst = 1'b0;
        #1;
`ifdef WB_BYPASS_EN
        push("rel_B_pre", 32'h77); pop_check(busB);
`else
        push("rel_B_pre", 32'h0);  pop_check(busB);
`endif
        push("rel_cnt_pre", 32'h0); pop_check(wb_count);
        @(negedge clk);
        idle();
        #1;
        push("rel_r9", 32'h77);    pop_check(busB);
        push("rel_count", 32'd1);  pop_check(wb_count);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
